deser8: RTL

Serial-in/parallel-out receiver. It reassembles an 8-bit word from a one-bit-per-cycle serial stream, such as the MSB or LSB stream produced by shifter8 when repeatedly shifted by 1. The bit order (MSB-first or LSB-first) is selectable per frame. Completed words are presented on a held valid/ack handshake, with sticky overrun detection. It is the receiving end of the shifter8 serial link, used in the shifter/counter/register-file lab datapath.

---
 rtl/deser8.sv | 114 +++++++++++
 1 files changed

// File: rtl/deser8.sv
// Serial-in/parallel-out receiver: assembles 8-bit words from a 1-bit stream,
// MSB- or LSB-first per frame, with a valid/ack handshake and sticky overrun.
module deser8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       s_in,
  input  logic       msb_first,
  input  logic       ack,
  output logic [7:0] d_out,
  output logic       valid,
  output logic       busy,
  output logic [2:0] cnt,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] sr, sr_next;
  logic       order, order_next;
  logic [7:0] d_out_next;
  logic       valid_next, busy_next, overrun_next;
  logic [2:0] cnt_next;
  logic [7:0] start_word, shift_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sr      <= 8'h00;
      order   <= 1'b1;
      d_out   <= 8'h00;
      valid   <= 1'b0;
      busy    <= 1'b0;
      cnt     <= 3'd0;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      sr      <= sr_next;
      order   <= order_next;
      d_out   <= d_out_next;
      valid   <= valid_next;
      busy    <= busy_next;
      cnt     <= cnt_next;
      overrun <= overrun_next;
    end
  end

  // The first bit of a new frame uses the incoming order; later bits use the latched one.
  assign start_word = msb_first ? {sr[6:0], s_in} : {s_in, sr[7:1]};
  assign shift_word = order     ? {sr[6:0], s_in} : {s_in, sr[7:1]};

  always_comb begin
    state_next   = state;
    sr_next      = sr;
    order_next   = order;
    d_out_next   = d_out;
    valid_next   = valid;
    busy_next    = busy;
    cnt_next     = cnt;
    overrun_next = overrun;

    case (state)
      IDLE: begin
        if (start) begin
          order_next = msb_first;
          sr_next    = start_word;
          cnt_next   = 3'd1;
          busy_next  = 1'b1;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        sr_next = shift_word;
        if (cnt == 3'd7) begin
          d_out_next = shift_word;
          valid_next = 1'b1;
          busy_next  = 1'b0;
          cnt_next   = 3'd0;
          state_next = DONE;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end

      DONE: begin
        if (ack) begin
          valid_next = 1'b0;
          if (start) begin
            order_next = msb_first;
            sr_next    = start_word;
            cnt_next   = 3'd1;
            busy_next  = 1'b1;
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end else if (start) begin
          overrun_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
